// File: rtl/ifmap_row_feeder.sv
// ifmap_row_feeder: streams an IFmap region from SRAM into the IF buffer, tagging
// each word with start/end-of-row markers and absorbing back-pressure in a 2-entry skid.
module ifmap_row_feeder #(
    parameter int IF_SCRATCH_WIDTH = 16,
    parameter int MEM_ADDR_LEN     = 10,
    parameter int LEN_WIDTH        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MEM_ADDR_LEN-1:0]     base_addr,
    input  logic [LEN_WIDTH-1:0]        row_len,
    input  logic [LEN_WIDTH-1:0]        num_rows,
    output logic                        mem_ren,
    output logic [MEM_ADDR_LEN-1:0]     mem_addr,
    input  logic [IF_SCRATCH_WIDTH-1:0] mem_rdata,
    output logic                        IF_wen,
    output logic [IF_SCRATCH_WIDTH+1:0] IF_din,
    input  logic                        IF_full,
    output logic                        busy,
    output logic                        done
);
    localparam int DW = IF_SCRATCH_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ZERO} state_t;

    state_t                  state;
    logic [MEM_ADDR_LEN-1:0] addr;
    logic [LEN_WIDTH-1:0]    rl, nr, col, row;
    logic                    inflight;
    logic [1:0]              tag_q;
    logic [DW-1:0]           skid0, skid1, last_q, wdata;
    logic [1:0]              count;
    logic [2:0]              occ;
    logic                    issue, pop, last_col, last_rd;

    // occupancy counts the skid plus the read whose data lands next edge
    assign pop      = (count != 2'd0) && !IF_full;
    assign occ      = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue    = (state == RUN) && (occ < 3'd2);
    assign last_col = col == rl - LEN_WIDTH'(1);
    assign last_rd  = last_col && (row == nr - LEN_WIDTH'(1));
    assign wdata    = {tag_q, mem_rdata};

    assign mem_ren  = issue;
    assign mem_addr = addr;
    assign IF_wen   = pop;
    assign IF_din   = pop ? skid0 : last_q;
    assign busy     = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr     <= '0;
            rl       <= '0;
            nr       <= '0;
            col      <= '0;
            row      <= '0;
            inflight <= 1'b0;
            tag_q    <= '0;
            skid0    <= '0;
            skid1    <= '0;
            last_q   <= '0;
            count    <= '0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                tag_q <= {col == '0, last_col};
                addr  <= addr + MEM_ADDR_LEN'(1);
                col   <= last_col ? '0 : col + LEN_WIDTH'(1);
                if (last_col)
                    row <= row + LEN_WIDTH'(1);
            end
            if (pop)
                last_q <= skid0;
            if (pop ? (count == 2'd2 || inflight) : (inflight && count == 2'd0))
                skid0 <= (pop && count == 2'd2) ? skid1 : wdata;
            if (inflight && (count - 2'(pop)) == 2'd1)
                skid1 <= wdata;
            count <= count + 2'(inflight) - 2'(pop);
            case (state)
                IDLE: if (start) begin
                    rl    <= row_len;
                    nr    <= num_rows;
                    addr  <= base_addr;
                    col   <= '0;
                    row   <= '0;
                    state <= (row_len == '0 || num_rows == '0) ? ZERO : RUN;
                end
                ZERO: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                RUN: if (issue && last_rd)
                    state <= DRAIN;
                DRAIN: if (!inflight && count == 2'(pop)) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ifmap_row_feeder.md
Name: ifmap_row_feeder

Overview:
Upstream stage of the PE's IFmap input buffer. Streams an IFmap region from a synchronous-read feature-map SRAM into the IF buffer write port. Each word is tagged with the 2-bit row markers the PE scratchpad expects: bit17 = start-of-row, bit16 = end-of-row. Absorbs IF buffer back-pressure with a 2-entry skid buffer and sustains 1 word/cycle when the buffer is not full.

Parameters:
IF_SCRATCH_WIDTH, 16, pixel data width.
MEM_ADDR_LEN, 10, feature-map SRAM address width.
LEN_WIDTH, 8, width of row_len and num_rows.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous reset, active-low (0 = reset).
start  input  1  single-cycle request; sampled only in IDLE.
base_addr  input  MEM_ADDR_LEN  first SRAM address; latched on accepted start.
row_len  input  LEN_WIDTH  words per row; latched on accepted start.
num_rows  input  LEN_WIDTH  rows to stream; latched on accepted start.
mem_ren  output  1  SRAM read enable.
mem_addr  output  MEM_ADDR_LEN  SRAM read address.
mem_rdata  input  IF_SCRATCH_WIDTH  SRAM data, valid the cycle after mem_ren.
IF_wen  output  1  IF buffer write strobe.
IF_din  output  IF_SCRATCH_WIDTH+2  {sor, eor, data}.
IF_full  input  1  IF buffer full; no write may be issued while high.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse at job completion.

Behaviour:
- Reset (rst=0, asynchronous) forces: state IDLE, mem_ren=0, mem_addr=0, IF_wen=0, IF_din=0, busy=0, done=0, skid empty, counters 0, in-flight flag 0.
- FSM states:
  - IDLE: start=1 latches configuration. Next state is RUN, or ZERO if row_len==0 or num_rows==0.
  - ZERO: done=1 for one cycle, no reads, no writes. Returns to IDLE.
  - RUN: issues reads. After the last read is issued, moves to DRAIN.
  - DRAIN: waits until the skid buffer is empty and no read is in flight, then asserts done=1 and returns to IDLE.
- start is ignored outside IDLE.
- Read issue:
  - mem_ren=1 in RUN when (skid_count − pop + inflight) < 2. pop = IF_wen this cycle.
  - mem_addr = base_addr + linear index, computed modulo 2^MEM_ADDR_LEN (wrap, no error).
  - Column and row counters advance on each issue.
  - Tags are computed at issue time and travel with the read: sor=(col==0), eor=(col==row_len−1). row_len==1 gives tag 2'b11.
- Capture: the cycle after mem_ren, mem_rdata and its tags are pushed into the skid FIFO (2 entries, in order). Overflow is impossible by construction.
- Output:
  - IF_wen = skid non-empty AND !IF_full.
  - IF_din = skid head (combinational from registers).
  - Head pops on the edge where IF_wen=1.
  - When IF_wen=0, IF_din holds its last value.
- Latency:
  - start high in cycle C0 gives mem_ren in C1 and first IF_wen in C3, provided IF_full=0.
  - Steady-state throughput is 1 write/cycle.
- done / busy:
  - done asserts in the cycle after the final IF_wen handshake. busy=0 in that same cycle.
  - done is never asserted together with IF_wen.
- Back-pressure: when IF_full rises, at most 2 words are held. Reads stall; no word is lost or duplicated. Stream resumes the cycle IF_full falls.
- IF_full with an empty skid has no effect.
- Reset mid-job: all state clears immediately. No further mem_ren or IF_wen until a new start after rst returns to 1.
- Total writes per job = row_len × num_rows, exactly.

Test Plan:
1. base=0x010, row_len=3, num_rows=2, SRAM[0x10..0x15]=161,190,−161,−81,50,28, IF_full=0 -> IF_din = 0x200A1, 0x000BE, 0x1FF5F, 0x2FFAF, 0x00032, 0x1001C on 6 consecutive cycles starting C3; done one cycle after the 6th write.
2. Same job, IF_full=1 during C4–C8 -> identical 6-word sequence, no loss or duplication; IF_wen=0 whenever IF_full=1; mem_ren stalls within 1 cycle.
3. row_len=1, num_rows=3 -> 3 writes, each with tag 2'b11.
4. row_len=0 or num_rows=0 -> no mem_ren, no IF_wen, done pulses exactly once, 2 cycles after start.
5. base=0x3FE, row_len=4, num_rows=1 -> mem_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
6. rst=0 pulsed after the 2nd write of scenario 1 -> all outputs 0 immediately; a second start runs scenario 1 correctly from word 0. A start asserted while busy during scenario 1 is ignored.
